// File: rtl/inst_cache_refill_pkg.sv
// Shared definitions for the instruction-cache line-refill engine:
// FSM state encoding, AXI burst/response constants and line geometry.
package inst_cache_refill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_e;

    localparam int WORD_WIDTH  = 32;
    localparam int LINE_WORDS  = 8;
    localparam int LINE_WIDTH  = WORD_WIDTH * LINE_WORDS;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_AR_ID      = 4'd0;
    localparam logic [7:0] AXI_AR_LEN     = 8'd7;
    localparam logic [2:0] AXI_AR_SIZE    = 3'd2;

    // A beat is faulty on a non-OKAY response or when rlast disagrees with the beat count.
    function automatic logic beat_err(input logic [1:0] rresp,
                                      input logic       rlast,
                                      input logic       last_beat);
        return (rresp != AXI_RESP_OKAY) || (rlast != last_beat);
    endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Instruction-cache line refill: one 8-beat AXI read burst assembled into a
// 256-bit line and written to the data RAM. Optional ICACHE_CRITICAL_WORD_FIRST_EN.
module inst_cache_refill
    import inst_cache_refill_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int BANK_NUM     = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   miss_req,
    input  logic [31:0]            miss_addr,
    output logic                   busy,
    output logic                   refill_done,
    output logic                   refill_err,
    output logic                   crit_valid,
    output logic [31:0]            crit_data,
    output logic [3:0]             arid,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [31:0]            araddr,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic                   ram_en,
    output logic [31:0]            ram_wen,
    output logic [INDEX_WIDTH-1:0] ram_index,
    output logic [255:0]           ram_wdata
);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam int ADDR_LSB = 2;
    localparam logic [1:0] BURST_TYPE = AXI_BURST_WRAP;
`else
    localparam int ADDR_LSB = OFFSET_WIDTH;
    localparam logic [1:0] BURST_TYPE = AXI_BURST_INCR;
`endif

    refill_state_e       r_state;
    refill_state_e       w_state_next;
    logic [31:ADDR_LSB]  r_addr;
    logic [2:0]          r_start_word;
    logic [2:0]          r_beat_cnt;
    logic                r_err;
    logic [31:0]         r_line [BANK_NUM];
    logic [255:0]        w_line_flat;
    logic [2:0]          w_slot;
    logic                w_r_hs;
    logic                w_last_beat;
    logic                w_unused_addr_bits;

    logic                r_busy;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_ram_en;
    logic [31:0]         r_ram_wen;
    logic                r_refill_done;
    logic                r_refill_err;

    assign w_r_hs             = (r_state == ST_R) && rvalid;
    assign w_last_beat        = (r_beat_cnt == 3'd7);
    assign w_slot             = r_start_word + r_beat_cnt;
    assign w_unused_addr_bits = ^miss_addr[ADDR_LSB-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (miss_req) w_state_next = ST_AR;
                else          w_state_next = ST_IDLE;
            end
            ST_AR: begin
                if (arready) w_state_next = ST_R;
                else         w_state_next = ST_AR;
            end
            ST_R: begin
                if (w_r_hs && w_last_beat) w_state_next = ST_WRITE;
                else                       w_state_next = ST_R;
            end
            ST_WRITE: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Miss address and first word slot are captured only when a refill starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr       <= '0;
            r_start_word <= 3'd0;
        end else if ((r_state == ST_IDLE) && miss_req) begin
            r_addr <= miss_addr[31:ADDR_LSB];
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            r_start_word <= miss_addr[4:2];
`else
            r_start_word <= 3'd0;
`endif
        end
    end

    // Beat counting and line assembly; the count, not rlast, ends the burst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beat_cnt <= 3'd0;
            for (int i = 0; i < BANK_NUM; i++) begin
                r_line[i] <= 32'h0000_0000;
            end
        end else if (w_r_hs) begin
            r_line[w_slot] <= rdata;
            r_beat_cnt     <= r_beat_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_err <= 1'b0;
        end else if (w_r_hs && beat_err(rresp, rlast, w_last_beat)) begin
            r_err <= 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy        <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_wen     <= 32'h0000_0000;
            r_refill_done <= 1'b0;
            r_refill_err  <= 1'b0;
        end else begin
            r_busy        <= (w_state_next != ST_IDLE);
            r_arvalid     <= (w_state_next == ST_AR);
            r_rready      <= (w_state_next == ST_R);
            r_ram_en      <= (w_state_next == ST_WRITE);
            r_ram_wen     <= {32{w_state_next == ST_WRITE}};
            r_refill_done <= (w_state_next == ST_DONE);
            r_refill_err  <= (w_state_next == ST_DONE) && r_err;
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic        r_crit_valid;
    logic [31:0] r_crit_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crit_valid <= 1'b0;
            r_crit_data  <= 32'h0000_0000;
        end else if (w_r_hs && (r_beat_cnt == 3'd0)) begin
            r_crit_valid <= 1'b1;
            r_crit_data  <= rdata;
        end else begin
            r_crit_valid <= 1'b0;
        end
    end

    assign crit_valid = r_crit_valid;
    assign crit_data  = r_crit_data;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = 32'h0000_0000;
`endif

    // Word 0 lands in the most significant bits, matching the RAM read path.
    always_comb begin
        w_line_flat = 256'd0;
        for (int i = 0; i < BANK_NUM; i++) begin
            w_line_flat[(BANK_NUM-1-i)*32 +: 32] = r_line[i];
        end
    end

    assign busy        = r_busy;
    assign refill_done = r_refill_done;
    assign refill_err  = r_refill_err;
    assign arid        = AXI_AR_ID;
    assign arlen       = AXI_AR_LEN;
    assign arsize      = AXI_AR_SIZE;
    assign arburst     = BURST_TYPE;
    assign araddr      = {r_addr, {ADDR_LSB{1'b0}}};
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign ram_en      = r_ram_en;
    assign ram_wen     = r_ram_wen;
    assign ram_index   = r_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
    assign ram_wdata   = w_line_flat;

endmodule

// File: tb/tb_inst_cache_refill.sv
// Self-checking bench for inst_cache_refill: table of refill scenarios with
// hand-computed lines, plus reset-state and mid-burst reset sequences.
module tb_inst_cache_refill;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit         CRIT_EN   = 1'b1;
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam bit         CRIT_EN   = 1'b0;
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = 32'd0;
    logic         busy, refill_done, refill_err, crit_valid;
    logic [31:0]  crit_data;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  rdata = 32'd0;
    logic [1:0]   rresp = 2'b00;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic         ram_en;
    logic [31:0]  ram_wen;
    logic [6:0]   ram_index;
    logic [255:0] ram_wdata;

    inst_cache_refill dut (
        .clk(clk), .resetn(resetn), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .refill_done(refill_done), .refill_err(refill_err),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_index(ram_index), .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  beats [8];
        int           ar_delay;
        int           r_gap;
        int           bad_beat;
        int           rlast_beat;
        bit           hold_req;
        logic [31:0]  exp_araddr;
        logic [6:0]   exp_index;
        logic [255:0] exp_wdata;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_axi();
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        rdata   = 32'd0;
    endtask

    task automatic run_refill(input vec_t v, input string tag);
        int          cyc = 0;
        int          beat = 0;
        int          gap_cnt = 0;
        int          ar_wait = 0;
        int          en_cnt = 0;
        int          crit_cnt = 0;
        int          done_cyc = 0;
        bit          ar_bad = 1'b0;
        bit          wen_bad = 1'b0;
        logic        done_err = 1'b0;
        logic [255:0] wd = 256'd0;
        logic [6:0]  idx = 7'd0;
        logic [31:0] crit_d = 32'd0;
        logic [31:0] exp_crit;
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = v.addr;
        while (done_cyc == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!v.hold_req) miss_req = 1'b0;
            clear_axi();
            if (arvalid) begin
                if (araddr !== v.exp_araddr || arburst !== EXP_BURST) ar_bad = 1'b1;
                arready = (ar_wait >= v.ar_delay);
                ar_wait++;
            end
            if (rready && beat < 8) begin
                if (gap_cnt < v.r_gap) begin
                    gap_cnt++;
                end else begin
                    rvalid  = 1'b1;
                    rdata   = v.beats[beat];
                    rresp   = (beat == v.bad_beat) ? 2'b10 : 2'b00;
                    rlast   = (beat == v.rlast_beat);
                    beat++;
                    gap_cnt = 0;
                end
            end
            if (ram_en) begin
                en_cnt++;
                wd  = ram_wdata;
                idx = ram_index;
                if (ram_wen !== 32'hFFFF_FFFF) wen_bad = 1'b1;
            end else if (ram_wen !== 32'd0) begin
                wen_bad = 1'b1;
            end
            if (crit_valid) begin
                crit_cnt++;
                crit_d = crit_data;
            end
            if (refill_done) begin
                done_cyc = cyc;
                done_err = refill_err;
            end
        end
        miss_req = 1'b0;
        exp_crit = CRIT_EN ? v.beats[0] : 32'd0;
        check({tag, "_done_seen"}, 256'(done_cyc != 0), 256'(1));
        if (v.exp_lat != 0) check({tag, "_latency"}, 256'(done_cyc), 256'(v.exp_lat));
        check({tag, "_ar_stable"}, 256'(ar_bad), 256'(0));
        check({tag, "_beats"}, 256'(beat), 256'(8));
        check({tag, "_ram_en_pulses"}, 256'(en_cnt), 256'(1));
        check({tag, "_ram_wen"}, 256'(wen_bad), 256'(0));
        check({tag, "_wdata"}, wd, v.exp_wdata);
        check({tag, "_index"}, 256'(idx), 256'(v.exp_index));
        check({tag, "_err"}, 256'(done_err), 256'(v.exp_err));
        check({tag, "_crit_cnt"}, 256'(crit_cnt), 256'(CRIT_EN ? 1 : 0));
        check({tag, "_crit_data"}, 256'(crit_d), 256'(exp_crit));
        @(negedge clk);
        check({tag, "_idle_after"}, 256'(busy), 256'(0));
    endtask

    initial begin
        // vector 0 depends on the burst mode: INCR at 0x1234, or critical word at 0x214
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        vecs[0].addr = 32'h0000_0214;
        for (int k = 0; k < 8; k++) vecs[0].beats[k] = 32'h0000_00A0 + 32'(k);
        vecs[0].exp_araddr = 32'h0000_0214;
        vecs[0].exp_index  = 7'h10;
        vecs[0].exp_wdata  = 256'h000000A3_000000A4_000000A5_000000A6_000000A7_000000A0_000000A1_000000A2;
`else
        vecs[0].addr = 32'h0000_1234;
        for (int k = 0; k < 8; k++) vecs[0].beats[k] = 32'h1111_1111 * 32'(k + 1);
        vecs[0].exp_araddr = 32'h0000_1220;
        vecs[0].exp_index  = 7'h11;
        vecs[0].exp_wdata  = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
`endif
        vecs[0].ar_delay = 0; vecs[0].r_gap = 0; vecs[0].bad_beat = 8; vecs[0].rlast_beat = 7;
        vecs[0].hold_req = 1'b0; vecs[0].exp_err = 1'b0; vecs[0].exp_lat = 11;

        vecs[1].addr = 32'h0000_2040;
        for (int k = 0; k < 8; k++) vecs[1].beats[k] = 32'hC0DE_0000 + 32'(k);
        vecs[1].ar_delay = 3; vecs[1].r_gap = 2; vecs[1].bad_beat = 8; vecs[1].rlast_beat = 7;
        vecs[1].hold_req = 1'b0; vecs[1].exp_araddr = 32'h0000_2040; vecs[1].exp_index = 7'h02;
        vecs[1].exp_wdata = 256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007;
        vecs[1].exp_err = 1'b0; vecs[1].exp_lat = 30;

        vecs[2].addr = 32'h0000_0FE0;
        for (int k = 0; k < 8; k++) vecs[2].beats[k] = 32'hE000_0000 + 32'(k);
        vecs[2].ar_delay = 0; vecs[2].r_gap = 0; vecs[2].bad_beat = 3; vecs[2].rlast_beat = 7;
        vecs[2].hold_req = 1'b1; vecs[2].exp_araddr = 32'h0000_0FE0; vecs[2].exp_index = 7'h7F;
        vecs[2].exp_wdata = 256'hE0000000_E0000001_E0000002_E0000003_E0000004_E0000005_E0000006_E0000007;
        vecs[2].exp_err = 1'b1; vecs[2].exp_lat = 11;

        vecs[3].addr = 32'h0000_0000;
        for (int k = 0; k < 8; k++) vecs[3].beats[k] = 32'h5A5A_5A50 + 32'(k);
        vecs[3].ar_delay = 0; vecs[3].r_gap = 0; vecs[3].bad_beat = 8; vecs[3].rlast_beat = 7;
        vecs[3].hold_req = 1'b0; vecs[3].exp_araddr = 32'h0000_0000; vecs[3].exp_index = 7'h00;
        vecs[3].exp_wdata = 256'h5A5A5A50_5A5A5A51_5A5A5A52_5A5A5A53_5A5A5A54_5A5A5A55_5A5A5A56_5A5A5A57;
        vecs[3].exp_err = 1'b0; vecs[3].exp_lat = 11;

        vecs[4].addr = 32'h8000_0C60;
        for (int k = 0; k < 8; k++) vecs[4].beats[k] = 32'h1234_5670 + 32'(k);
        vecs[4].ar_delay = 0; vecs[4].r_gap = 0; vecs[4].bad_beat = 8; vecs[4].rlast_beat = 5;
        vecs[4].hold_req = 1'b0; vecs[4].exp_araddr = 32'h8000_0C60; vecs[4].exp_index = 7'h63;
        vecs[4].exp_wdata = 256'h12345670_12345671_12345672_12345673_12345674_12345675_12345676_12345677;
        vecs[4].exp_err = 1'b1; vecs[4].exp_lat = 11;

        vecs[5].addr = 32'h0000_7FE0;
        for (int k = 0; k < 8; k++) vecs[5].beats[k] = 32'h0F0F_0F00 + 32'(k);
        vecs[5].ar_delay = 1; vecs[5].r_gap = 1; vecs[5].bad_beat = 7; vecs[5].rlast_beat = 7;
        vecs[5].hold_req = 1'b0; vecs[5].exp_araddr = 32'h0000_7FE0; vecs[5].exp_index = 7'h7F;
        vecs[5].exp_wdata = 256'h0F0F0F00_0F0F0F01_0F0F0F02_0F0F0F03_0F0F0F04_0F0F0F05_0F0F0F06_0F0F0F07;
        vecs[5].exp_err = 1'b1; vecs[5].exp_lat = 20;

        repeat (2) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_arvalid", 256'(arvalid), 256'(0));
        check("rst_rready", 256'(rready), 256'(0));
        check("rst_ram_en", 256'(ram_en), 256'(0));
        check("rst_ram_wen", 256'(ram_wen), 256'(0));
        check("rst_done", 256'({refill_done, refill_err, crit_valid}), 256'(0));
        check("rst_wdata", ram_wdata, 256'd0);
        check("rst_ar_consts", 256'({arid, arlen, arsize, arburst}), 256'({4'd0, 8'd7, 3'd2, EXP_BURST}));
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_refill(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a burst, after three beats have been accepted.
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_3000;
        @(negedge clk);
        miss_req = 1'b0;
        check("mid_arvalid", 256'(arvalid), 256'(1));
        arready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            clear_axi();
            check($sformatf("mid_rready%0d", b), 256'(rready), 256'(1));
            rvalid = 1'b1;
            rdata  = 32'hDEAD_0000 + 32'(b);
            rlast  = 1'b0;
        end
        @(negedge clk);
        clear_axi();
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_rready", 256'(rready), 256'(0));
        check("mid_rst_outputs", 256'({arvalid, ram_en, refill_done, refill_err}), 256'(0));
        check("mid_rst_wdata", ram_wdata, 256'd0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_ram_en", 256'(ram_en), 256'(0));
        end
        resetn = 1'b1;
        run_refill(vecs[3], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
